// File: rtl/axi4lite_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter.
// A single FSM keeps exactly one transaction outstanding on the shared slave.
// Masters are chosen round-robin. Within the granted master, a write beats a read.
// The master that is not granted sees every output held at zero.
module axi4lite_arb2 (
    input  logic        clk_i,
    input  logic        rst_i,

    // master 0
    input  logic        inport0_awvalid_i,
    input  logic [31:0] inport0_awaddr_i,
    input  logic        inport0_wvalid_i,
    input  logic [31:0] inport0_wdata_i,
    input  logic [3:0]  inport0_wstrb_i,
    input  logic        inport0_bready_i,
    input  logic        inport0_arvalid_i,
    input  logic [31:0] inport0_araddr_i,
    input  logic        inport0_rready_i,
    output logic        inport0_awready_o,
    output logic        inport0_wready_o,
    output logic        inport0_bvalid_o,
    output logic [1:0]  inport0_bresp_o,
    output logic        inport0_arready_o,
    output logic        inport0_rvalid_o,
    output logic [31:0] inport0_rdata_o,
    output logic [1:0]  inport0_rresp_o,

    // master 1
    input  logic        inport1_awvalid_i,
    input  logic [31:0] inport1_awaddr_i,
    input  logic        inport1_wvalid_i,
    input  logic [31:0] inport1_wdata_i,
    input  logic [3:0]  inport1_wstrb_i,
    input  logic        inport1_bready_i,
    input  logic        inport1_arvalid_i,
    input  logic [31:0] inport1_araddr_i,
    input  logic        inport1_rready_i,
    output logic        inport1_awready_o,
    output logic        inport1_wready_o,
    output logic        inport1_bvalid_o,
    output logic [1:0]  inport1_bresp_o,
    output logic        inport1_arready_o,
    output logic        inport1_rvalid_o,
    output logic [31:0] inport1_rdata_o,
    output logic [1:0]  inport1_rresp_o,

    // shared slave
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic        outport_rready_o,
    input  logic        outport_awready_i,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;   // index of the master that owns the slave
    logic   last_q,  last_d;    // index of the master granted most recently

    // ------------------------------------------------------------------
    // Master-side signals gathered into index-able arrays
    // ------------------------------------------------------------------
    logic [1:0]  in_awvalid;
    logic [1:0]  in_wvalid;
    logic [1:0]  in_bready;
    logic [1:0]  in_arvalid;
    logic [1:0]  in_rready;
    logic [31:0] in_awaddr [2];
    logic [31:0] in_wdata  [2];
    logic [3:0]  in_wstrb  [2];
    logic [31:0] in_araddr [2];

    assign in_awvalid   = {inport1_awvalid_i, inport0_awvalid_i};
    assign in_wvalid    = {inport1_wvalid_i,  inport0_wvalid_i};
    assign in_bready    = {inport1_bready_i,  inport0_bready_i};
    assign in_arvalid   = {inport1_arvalid_i, inport0_arvalid_i};
    assign in_rready    = {inport1_rready_i,  inport0_rready_i};
    assign in_awaddr[0] = inport0_awaddr_i;
    assign in_awaddr[1] = inport1_awaddr_i;
    assign in_wdata[0]  = inport0_wdata_i;
    assign in_wdata[1]  = inport1_wdata_i;
    assign in_wstrb[0]  = inport0_wstrb_i;
    assign in_wstrb[1]  = inport1_wstrb_i;
    assign in_araddr[0] = inport0_araddr_i;
    assign in_araddr[1] = inport1_araddr_i;

    // Per-master request decode. A write needs both its address and its
    // data to be presented before it counts as a request.
    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] any_req;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign wr_req[gi]  = in_awvalid[gi] & in_wvalid[gi];
            assign rd_req[gi]  = in_arvalid[gi];
            assign any_req[gi] = wr_req[gi] | rd_req[gi];
        end
    endgenerate

    // Handshake qualifiers on the slave side.
    // The address and data must both be accepted in the same cycle.
    logic wr_accept;
    logic rd_accept;
    logic wr_done;
    logic rd_done;

    assign wr_accept = (state_q == ST_WR_REQ)  & outport_awready_i & outport_wready_i;
    assign rd_accept = (state_q == ST_RD_REQ)  & outport_arready_i;
    assign wr_done   = (state_q == ST_WR_RESP) & outport_bvalid_i & in_bready[grant_q];
    assign rd_done   = (state_q == ST_RD_RESP) & outport_rvalid_i & in_rready[grant_q];

    // ------------------------------------------------------------------
    // FSM process 1: state, grant and round-robin history registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;    // master 0 wins the first tie after reset
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state. New grants are decided only in IDLE.
    // Requests arriving at other times stay pending until the next IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|any_req) begin
                    if (any_req[0] && any_req[1]) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = any_req[1];
                    end
                    last_d  = grant_d;
                    state_d = wr_req[grant_d] ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (wr_accept) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (wr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (rd_accept) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (rd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: slave-side outputs. Address and data fields are zero
    // whenever their valid is low, so idle buses stay quiet.
    // ------------------------------------------------------------------
    always_comb begin
        outport_awvalid_o = 1'b0;
        outport_awaddr_o  = 32'd0;
        outport_wvalid_o  = 1'b0;
        outport_wdata_o   = 32'd0;
        outport_wstrb_o   = 4'd0;
        outport_bready_o  = 1'b0;
        outport_arvalid_o = 1'b0;
        outport_araddr_o  = 32'd0;
        outport_rready_o  = 1'b0;
        case (state_q)
            ST_WR_REQ: begin
                outport_awvalid_o = 1'b1;
                outport_awaddr_o  = in_awaddr[grant_q];
                outport_wvalid_o  = 1'b1;
                outport_wdata_o   = in_wdata[grant_q];
                outport_wstrb_o   = in_wstrb[grant_q];
            end
            ST_WR_RESP: begin
                outport_bready_o  = in_bready[grant_q];
            end
            ST_RD_REQ: begin
                outport_arvalid_o = 1'b1;
                outport_araddr_o  = in_araddr[grant_q];
            end
            ST_RD_RESP: begin
                outport_rready_o  = in_rready[grant_q];
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Master-side outputs. Only the granted master sees slave handshakes
    // and responses. The other master sees every output at zero.
    // ------------------------------------------------------------------
    logic [1:0]  out_awready;
    logic [1:0]  out_wready;
    logic [1:0]  out_bvalid;
    logic [1:0]  out_arready;
    logic [1:0]  out_rvalid;
    logic [1:0]  out_bresp [2];
    logic [31:0] out_rdata [2];
    logic [1:0]  out_rresp [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            logic owner;
            logic b_fwd;
            logic r_fwd;

            assign owner = (grant_q == 1'(gi));
            assign b_fwd = owner & (state_q == ST_WR_RESP) & outport_bvalid_i;
            assign r_fwd = owner & (state_q == ST_RD_RESP) & outport_rvalid_i;

            assign out_awready[gi] = owner & wr_accept;
            assign out_wready[gi]  = owner & wr_accept;
            assign out_arready[gi] = owner & rd_accept;
            assign out_bvalid[gi]  = b_fwd;
            assign out_bresp[gi]   = b_fwd ? outport_bresp_i : 2'd0;
            assign out_rvalid[gi]  = r_fwd;
            assign out_rdata[gi]   = r_fwd ? outport_rdata_i : 32'd0;
            assign out_rresp[gi]   = r_fwd ? outport_rresp_i : 2'd0;
        end
    endgenerate

    assign inport0_awready_o = out_awready[0];
    assign inport0_wready_o  = out_wready[0];
    assign inport0_bvalid_o  = out_bvalid[0];
    assign inport0_bresp_o   = out_bresp[0];
    assign inport0_arready_o = out_arready[0];
    assign inport0_rvalid_o  = out_rvalid[0];
    assign inport0_rdata_o   = out_rdata[0];
    assign inport0_rresp_o   = out_rresp[0];

    assign inport1_awready_o = out_awready[1];
    assign inport1_wready_o  = out_wready[1];
    assign inport1_bvalid_o  = out_bvalid[1];
    assign inport1_bresp_o   = out_bresp[1];
    assign inport1_arready_o = out_arready[1];
    assign inport1_rvalid_o  = out_rvalid[1];
    assign inport1_rdata_o   = out_rdata[1];
    assign inport1_rresp_o   = out_rresp[1];

endmodule

// File: tb/tb_axi4lite_arb2.sv
// Directed self-checking bench for axi4lite_arb2.
// The bench plays both masters and the shared slave.
module tb_axi4lite_arb2;

    logic        clk_i;
    logic        rst_i;
    logic        inport0_awvalid_i, inport0_wvalid_i, inport0_bready_i, inport0_arvalid_i, inport0_rready_i;
    logic [31:0] inport0_awaddr_i, inport0_wdata_i, inport0_araddr_i;
    logic [3:0]  inport0_wstrb_i;
    logic        inport0_awready_o, inport0_wready_o, inport0_bvalid_o, inport0_arready_o, inport0_rvalid_o;
    logic [1:0]  inport0_bresp_o, inport0_rresp_o;
    logic [31:0] inport0_rdata_o;
    logic        inport1_awvalid_i, inport1_wvalid_i, inport1_bready_i, inport1_arvalid_i, inport1_rready_i;
    logic [31:0] inport1_awaddr_i, inport1_wdata_i, inport1_araddr_i;
    logic [3:0]  inport1_wstrb_i;
    logic        inport1_awready_o, inport1_wready_o, inport1_bvalid_o, inport1_arready_o, inport1_rvalid_o;
    logic [1:0]  inport1_bresp_o, inport1_rresp_o;
    logic [31:0] inport1_rdata_o;
    logic        outport_awvalid_o, outport_wvalid_o, outport_bready_o, outport_arvalid_o, outport_rready_o;
    logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o;
    logic [3:0]  outport_wstrb_o;
    logic        outport_awready_i, outport_wready_i, outport_bvalid_i, outport_arready_i, outport_rvalid_i;
    logic [1:0]  outport_bresp_i, outport_rresp_i;
    logic [31:0] outport_rdata_i;

    int errors = 0;
    int checks = 0;

    axi4lite_arb2 dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport0_awvalid_i(inport0_awvalid_i), .inport0_awaddr_i(inport0_awaddr_i),
        .inport0_wvalid_i(inport0_wvalid_i), .inport0_wdata_i(inport0_wdata_i), .inport0_wstrb_i(inport0_wstrb_i),
        .inport0_bready_i(inport0_bready_i), .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i),
        .inport0_rready_i(inport0_rready_i),
        .inport0_awready_o(inport0_awready_o), .inport0_wready_o(inport0_wready_o),
        .inport0_bvalid_o(inport0_bvalid_o), .inport0_bresp_o(inport0_bresp_o),
        .inport0_arready_o(inport0_arready_o), .inport0_rvalid_o(inport0_rvalid_o),
        .inport0_rdata_o(inport0_rdata_o), .inport0_rresp_o(inport0_rresp_o),
        .inport1_awvalid_i(inport1_awvalid_i), .inport1_awaddr_i(inport1_awaddr_i),
        .inport1_wvalid_i(inport1_wvalid_i), .inport1_wdata_i(inport1_wdata_i), .inport1_wstrb_i(inport1_wstrb_i),
        .inport1_bready_i(inport1_bready_i), .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i),
        .inport1_rready_i(inport1_rready_i),
        .inport1_awready_o(inport1_awready_o), .inport1_wready_o(inport1_wready_o),
        .inport1_bvalid_o(inport1_bvalid_o), .inport1_bresp_o(inport1_bresp_o),
        .inport1_arready_o(inport1_arready_o), .inport1_rvalid_o(inport1_rvalid_o),
        .inport1_rdata_o(inport1_rdata_o), .inport1_rresp_o(inport1_rresp_o),
        .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
        .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
        .outport_bready_o(outport_bready_o), .outport_arvalid_o(outport_arvalid_o),
        .outport_araddr_o(outport_araddr_o), .outport_rready_o(outport_rready_o),
        .outport_awready_i(outport_awready_i), .outport_wready_i(outport_wready_i),
        .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
        .outport_arready_i(outport_arready_i), .outport_rvalid_i(outport_rvalid_i),
        .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        inport0_awvalid_i = 0; inport0_awaddr_i = 0; inport0_wvalid_i = 0; inport0_wdata_i = 0;
        inport0_wstrb_i = 0; inport0_bready_i = 0; inport0_arvalid_i = 0; inport0_araddr_i = 0; inport0_rready_i = 0;
        inport1_awvalid_i = 0; inport1_awaddr_i = 0; inport1_wvalid_i = 0; inport1_wdata_i = 0;
        inport1_wstrb_i = 0; inport1_bready_i = 0; inport1_arvalid_i = 0; inport1_araddr_i = 0; inport1_rready_i = 0;
        outport_awready_i = 0; outport_wready_i = 0; outport_bvalid_i = 0; outport_bresp_i = 0;
        outport_arready_i = 0; outport_rvalid_i = 0; outport_rdata_i = 0; outport_rresp_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        outport_rvalid_i = 1'b1;
        outport_bvalid_i = 1'b1;
        inport0_rready_i = 1'b1;
        #3;
        checks++;
        if ({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o, outport_rready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outport_ctl: got %b expected 00000",
                     {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o, outport_rready_o});
        end
        checks++;
        if ({inport0_awready_o, inport0_wready_o, inport0_bvalid_o, inport0_arready_o, inport0_rvalid_o,
             inport1_awready_o, inport1_wready_o, inport1_bvalid_o, inport1_arready_o, inport1_rvalid_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_inport_ctl: got %b expected 0",
                     {inport0_awready_o, inport0_wready_o, inport0_bvalid_o, inport0_arready_o, inport0_rvalid_o,
                      inport1_awready_o, inport1_wready_o, inport1_bvalid_o, inport1_arready_o, inport1_rvalid_o});
        end
        checks++;
        if ({inport0_rdata_o, inport1_rdata_o, inport0_rresp_o, inport1_rresp_o, inport0_bresp_o, inport1_bresp_o,
             outport_awaddr_o, outport_araddr_o, outport_wdata_o, outport_wstrb_o} !== 0) begin
            errors++;
            $display("FAIL reset_data: got r0=%h r1=%h aw=%h ar=%h expected all 0",
                     inport0_rdata_o, inport1_rdata_o, outport_awaddr_o, outport_araddr_o);
        end
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        $display("[tb] reset released");
    endtask

    // Both masters read at once: master 0 first, master 1 next.
    task automatic test_read_tie();
        inport0_arvalid_i = 1; inport0_araddr_i = 32'h0000_0100;
        inport1_arvalid_i = 1; inport1_araddr_i = 32'h0000_0200;
        #1;
        checks++;
        if (outport_arvalid_o !== 1'b0) begin
            errors++; $display("FAIL tie_idle_no_valid: got %b expected 0", outport_arvalid_o);
        end
        step();
        checks++;
        if ({outport_arvalid_o, outport_araddr_o} !== {1'b1, 32'h0000_0100}) begin
            errors++; $display("FAIL tie_m0_ar: got v=%b a=%h expected v=1 a=00000100", outport_arvalid_o, outport_araddr_o);
        end
        outport_arready_i = 1; #1;
        checks++;
        if ({inport0_arready_o, inport1_arready_o} !== 2'b10) begin
            errors++; $display("FAIL tie_m0_arready: got %b expected 10", {inport0_arready_o, inport1_arready_o});
        end
        step();
        inport0_arvalid_i = 0; outport_arready_i = 0;
        outport_rvalid_i = 1; outport_rdata_i = 32'hCAFE_0001; outport_rresp_i = 2'b00; inport0_rready_i = 1;
        #1;
        checks++;
        if ({inport0_rvalid_o, inport0_rdata_o, inport0_rresp_o, outport_rready_o} !== {1'b1, 32'hCAFE_0001, 2'b00, 1'b1}) begin
            errors++; $display("FAIL tie_m0_r: got v=%b d=%h rr=%b expected v=1 d=cafe0001 rr=1",
                               inport0_rvalid_o, inport0_rdata_o, outport_rready_o);
        end
        checks++;
        if ({inport1_arready_o, inport1_rvalid_o, inport1_rdata_o} !== 0) begin
            errors++; $display("FAIL tie_m1_quiet: got v=%b d=%h expected 0", inport1_rvalid_o, inport1_rdata_o);
        end
        $display("[tb] read m0 addr=00000100 data=%h", inport0_rdata_o);
        step();
        outport_rvalid_i = 0; inport0_rready_i = 0;
        #1;
        checks++;
        if (outport_arvalid_o !== 1'b0) begin
            errors++; $display("FAIL tie_idle_gap: got %b expected 0", outport_arvalid_o);
        end
        step();
        checks++;
        if ({outport_arvalid_o, outport_araddr_o} !== {1'b1, 32'h0000_0200}) begin
            errors++; $display("FAIL tie_m1_ar: got v=%b a=%h expected v=1 a=00000200", outport_arvalid_o, outport_araddr_o);
        end
        outport_arready_i = 1; #1;
        checks++;
        if ({inport0_arready_o, inport1_arready_o} !== 2'b01) begin
            errors++; $display("FAIL tie_m1_arready: got %b expected 01", {inport0_arready_o, inport1_arready_o});
        end
        step();
        inport1_arvalid_i = 0; outport_arready_i = 0;
        outport_rvalid_i = 1; outport_rdata_i = 32'hCAFE_0002; outport_rresp_i = 2'b10; inport1_rready_i = 1;
        #1;
        checks++;
        if ({inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o, inport0_rvalid_o} !== {1'b1, 32'hCAFE_0002, 2'b10, 1'b0}) begin
            errors++; $display("FAIL tie_m1_r: got v=%b d=%h resp=%b m0v=%b expected v=1 d=cafe0002 resp=10 m0v=0",
                               inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o, inport0_rvalid_o);
        end
        $display("[tb] read m1 addr=00000200 data=%h", inport1_rdata_o);
        step();
        clear_inputs();
    endtask

    // Slave holds wready low for 3 cycles; the request must not complete.
    task automatic test_write_partial_ready();
        inport0_awvalid_i = 1; inport0_awaddr_i = 32'h10;
        inport0_wvalid_i = 1; inport0_wdata_i = 32'hA5A5_A5A5; inport0_wstrb_i = 4'hF;
        #1;
        checks++;
        if (outport_awvalid_o !== 1'b0) begin
            errors++; $display("FAIL wr_idle_no_valid: got %b expected 0", outport_awvalid_o);
        end
        step();
        checks++;
        if ({outport_awvalid_o, outport_wvalid_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o} !==
            {1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF}) begin
            errors++; $display("FAIL wr_out: got awv=%b wv=%b a=%h d=%h s=%h expected 1 1 00000010 a5a5a5a5 f",
                               outport_awvalid_o, outport_wvalid_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o);
        end
        outport_awready_i = 1; outport_wready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({inport0_awready_o, inport0_wready_o, outport_awvalid_o, outport_wvalid_o} !== 4'b0011) begin
                errors++; $display("FAIL wr_partial_%0d: got %b expected 0011", i,
                                   {inport0_awready_o, inport0_wready_o, outport_awvalid_o, outport_wvalid_o});
            end
            step();
        end
        outport_wready_i = 1; #1;
        checks++;
        if ({inport0_awready_o, inport0_wready_o, inport1_awready_o, inport1_wready_o} !== 4'b1100) begin
            errors++; $display("FAIL wr_accept: got %b expected 1100",
                               {inport0_awready_o, inport0_wready_o, inport1_awready_o, inport1_wready_o});
        end
        step();
        inport0_awvalid_i = 0; inport0_wvalid_i = 0; outport_awready_i = 0; outport_wready_i = 0;
        outport_bvalid_i = 1; outport_bresp_i = 2'b00; inport0_bready_i = 0;
        #1;
        checks++;
        if ({outport_awvalid_o, inport0_awready_o, inport0_wready_o, inport0_bvalid_o, outport_bready_o} !== 5'b00010) begin
            errors++; $display("FAIL wr_resp_wait: got %b expected 00010",
                               {outport_awvalid_o, inport0_awready_o, inport0_wready_o, inport0_bvalid_o, outport_bready_o});
        end
        step();
        inport0_bready_i = 1; #1;
        checks++;
        if ({inport0_bvalid_o, inport0_bresp_o, outport_bready_o, inport1_bvalid_o} !== 5'b10010) begin
            errors++; $display("FAIL wr_resp: got %b expected 10010",
                               {inport0_bvalid_o, inport0_bresp_o, outport_bready_o, inport1_bvalid_o});
        end
        $display("[tb] write m0 addr=00000010 data=a5a5a5a5 bresp=%b", inport0_bresp_o);
        step();
        clear_inputs();
    endtask

    // Master 1 writes and reads together: write first, then the read.
    task automatic test_write_then_read();
        // Stray slave responses in IDLE must be ignored.
        outport_rvalid_i = 1; outport_bvalid_i = 1; outport_rdata_i = 32'hFFFF_FFFF;
        inport0_rready_i = 1; inport0_bready_i = 1; inport1_rready_i = 1; inport1_bready_i = 1;
        #1;
        checks++;
        if ({outport_rready_o, outport_bready_o, inport0_rvalid_o, inport0_bvalid_o, inport1_rvalid_o, inport1_bvalid_o,
             inport0_rdata_o, inport1_rdata_o} !== 0) begin
            errors++; $display("FAIL stray_resp: got rr=%b br=%b r0v=%b r1v=%b expected 0",
                               outport_rready_o, outport_bready_o, inport0_rvalid_o, inport1_rvalid_o);
        end
        step();
        clear_inputs();
        inport1_awvalid_i = 1; inport1_awaddr_i = 32'h20; inport1_wvalid_i = 1;
        inport1_wdata_i = 32'hDEAD_BEEF; inport1_wstrb_i = 4'h3;
        inport1_arvalid_i = 1; inport1_araddr_i = 32'h30;
        step();
        checks++;
        if ({outport_awvalid_o, outport_arvalid_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o} !==
            {1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 4'h3}) begin
            errors++; $display("FAIL wr_first: got awv=%b arv=%b a=%h d=%h s=%h expected 1 0 00000020 deadbeef 3",
                               outport_awvalid_o, outport_arvalid_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o);
        end
        outport_awready_i = 1; outport_wready_i = 1; #1;
        checks++;
        if ({inport1_awready_o, inport1_wready_o, inport1_arready_o, inport0_awready_o, inport0_wready_o} !== 5'b11000) begin
            errors++; $display("FAIL wr_m1_accept: got %b expected 11000",
                               {inport1_awready_o, inport1_wready_o, inport1_arready_o, inport0_awready_o, inport0_wready_o});
        end
        step();
        inport1_awvalid_i = 0; inport1_wvalid_i = 0; outport_awready_i = 0; outport_wready_i = 0;
        outport_bvalid_i = 1; outport_bresp_i = 2'b00; inport1_bready_i = 1;
        #1;
        checks++;
        if ({inport1_bvalid_o, inport1_bresp_o, outport_arvalid_o, inport0_bvalid_o} !== 5'b10000) begin
            errors++; $display("FAIL wr_m1_resp: got %b expected 10000",
                               {inport1_bvalid_o, inport1_bresp_o, outport_arvalid_o, inport0_bvalid_o});
        end
        $display("[tb] write m1 addr=00000020 data=deadbeef bresp=%b", inport1_bresp_o);
        step();
        outport_bvalid_i = 0; inport1_bready_i = 0; #1;
        checks++;
        if (outport_arvalid_o !== 1'b0) begin
            errors++; $display("FAIL wr_rd_gap: got %b expected 0", outport_arvalid_o);
        end
        step();
        checks++;
        if ({outport_arvalid_o, outport_araddr_o} !== {1'b1, 32'h30}) begin
            errors++; $display("FAIL rd_m1_ar: got v=%b a=%h expected v=1 a=00000030", outport_arvalid_o, outport_araddr_o);
        end
        outport_arready_i = 1; #1;
        checks++;
        if ({inport1_arready_o, inport0_arready_o} !== 2'b10) begin
            errors++; $display("FAIL rd_m1_arready: got %b expected 10", {inport1_arready_o, inport0_arready_o});
        end
        step();
        inport1_arvalid_i = 0; outport_arready_i = 0;
        outport_rvalid_i = 1; outport_rdata_i = 32'h1234_5678; outport_rresp_i = 2'b00; inport1_rready_i = 1;
        #1;
        checks++;
        if ({inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o} !== {1'b1, 32'h1234_5678, 2'b00}) begin
            errors++; $display("FAIL rd_m1_data: got v=%b d=%h resp=%b expected v=1 d=12345678 resp=00",
                               inport1_rvalid_o, inport1_rdata_o, inport1_rresp_o);
        end
        checks++;
        if ({inport0_rvalid_o, inport0_rdata_o} !== 0) begin
            errors++; $display("FAIL rd_m0_quiet: got v=%b d=%h expected 0", inport0_rvalid_o, inport0_rdata_o);
        end
        $display("[tb] read m1 addr=00000030 data=%h", inport1_rdata_o);
        step();
        clear_inputs();
    endtask

    // Both masters request continuously: grants alternate 0,1,0,1...
    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        logic [1:0]  exp_sel;
        inport0_arvalid_i = 1; inport0_araddr_i = 32'hA000_0000;
        inport1_arvalid_i = 1; inport1_araddr_i = 32'hB000_0000;
        for (int k = 0; k < 8; k++) begin
            exp_addr = (k % 2 == 1) ? 32'hB000_0000 : 32'hA000_0000;
            exp_sel  = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            checks++;
            if (outport_arvalid_o !== 1'b0) begin
                errors++; $display("FAIL b2b_idle_%0d: got %b expected 0", k, outport_arvalid_o);
            end
            step();
            checks++;
            if ({outport_arvalid_o, outport_araddr_o} !== {1'b1, exp_addr}) begin
                errors++; $display("FAIL b2b_addr_%0d: got v=%b a=%h expected v=1 a=%h", k, outport_arvalid_o,
                                   outport_araddr_o, exp_addr);
            end
            outport_arready_i = 1; #1;
            checks++;
            if ({inport1_arready_o, inport0_arready_o} !== exp_sel) begin
                errors++; $display("FAIL b2b_arready_%0d: got %b expected %b", k,
                                   {inport1_arready_o, inport0_arready_o}, exp_sel);
            end
            step();
            outport_arready_i = 0; outport_rvalid_i = 1; outport_rdata_i = 32'h100 + k;
            inport0_rready_i = 1; inport1_rready_i = 1;
            #1;
            checks++;
            if ({inport1_rvalid_o, inport0_rvalid_o, inport0_rdata_o, inport1_rdata_o} !==
                {exp_sel, (exp_sel[0] ? 32'h100 + k : 32'd0), (exp_sel[1] ? 32'h100 + k : 32'd0)}) begin
                errors++; $display("FAIL b2b_rdata_%0d: got v=%b d0=%h d1=%h expected v=%b", k,
                                   {inport1_rvalid_o, inport0_rvalid_o}, inport0_rdata_o, inport1_rdata_o, exp_sel);
            end
            $display("[tb] b2b read %0d master=%0d addr=%h", k, k % 2, exp_addr);
            step();
            outport_rvalid_i = 0;
        end
        clear_inputs();
    endtask

    // Reset during RD_RESP with rvalid high abandons the read.
    task automatic test_reset_mid();
        inport0_arvalid_i = 1; inport0_araddr_i = 32'h40;
        step();
        outport_arready_i = 1;
        step();
        inport0_arvalid_i = 0; outport_arready_i = 0;
        outport_rvalid_i = 1; outport_rdata_i = 32'hBAD0_BAD0; inport0_rready_i = 0;
        #1;
        checks++;
        if ({inport0_rvalid_o, inport0_rdata_o} !== {1'b1, 32'hBAD0_BAD0}) begin
            errors++; $display("FAIL mid_pre: got v=%b d=%h expected v=1 d=bad0bad0", inport0_rvalid_o, inport0_rdata_o);
        end
        step();
        #1;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({inport0_rvalid_o, inport0_rdata_o, outport_rready_o, outport_arvalid_o, outport_awvalid_o} !== 0) begin
            errors++; $display("FAIL mid_async: got v=%b d=%h rr=%b expected 0", inport0_rvalid_o, inport0_rdata_o,
                               outport_rready_o);
        end
        inport0_rready_i = 1;
        step();
        step();
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        checks++;
        if ({inport0_rvalid_o, inport0_rdata_o, outport_rready_o} !== 0) begin
            errors++; $display("FAIL mid_stale: got v=%b d=%h rr=%b expected 0", inport0_rvalid_o, inport0_rdata_o,
                               outport_rready_o);
        end
        outport_rvalid_i = 0;
        inport0_arvalid_i = 1; inport0_araddr_i = 32'h50;
        inport1_arvalid_i = 1; inport1_araddr_i = 32'h60;
        step();
        checks++;
        if ({outport_arvalid_o, outport_araddr_o} !== {1'b1, 32'h50}) begin
            errors++; $display("FAIL mid_tie_after_reset: got v=%b a=%h expected v=1 a=00000050",
                               outport_arvalid_o, outport_araddr_o);
        end
        $display("[tb] reset mid-read, post-reset grant addr=%h", outport_araddr_o);
        clear_inputs();
        rst_i = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_read_tie();
        test_write_partial_ready();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
